ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 126 ++++++++++++
 tb/tb_ps2_host_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with inhibit, bit shifting, ACK check and timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic clk_prev, fe, cur_bit, timeout, abort;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [7:0] tx_byte, tx_byte_n;
  logic par, par_n, clk_drv_n, data_drv_n, busy_n, done_n, err_n;
  assign fe = clk_prev & ~clk_sync[1];
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  // idx 0..7 data LSB first, 8 parity, 9 stop (released line)
  assign cur_bit = (idx == 4'd8) ? par : (idx == 4'd9) ? 1'b1 : tx_byte[idx[2:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      clk_sync <= '0;
      data_sync <= '0;
      clk_prev <= 1'b0;
      cnt <= '0;
      idx <= '0;
      tx_byte <= '0;
      par <= 1'b0;
      ps2_clk_drive_low <= 1'b0;
      ps2_data_drive_low <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      clk_sync <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev <= clk_sync[1];
      cnt <= cnt_n;
      idx <= idx_n;
      tx_byte <= tx_byte_n;
      par <= par_n;
      ps2_clk_drive_low <= clk_drv_n;
      ps2_data_drive_low <= data_drv_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = fe ? '0 : cnt + 1'b1;
    idx_n = idx;
    tx_byte_n = tx_byte;
    par_n = par;
    clk_drv_n = ps2_clk_drive_low;
    data_drv_n = ps2_data_drive_low;
    busy_n = busy;
    done_n = 1'b0;
    err_n = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_start) begin
          state_n = INHIBIT;
          tx_byte_n = tx_data;
          par_n = ~^tx_data;
          busy_n = 1'b1;
          clk_drv_n = 1'b1;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n = START;
          idx_n = '0;
          clk_drv_n = 1'b0;
          data_drv_n = 1'b1;
        end
      end
      START, BITS: begin
        if (fe) begin
          data_drv_n = ~cur_bit;
          idx_n = idx + 1'b1;
          state_n = (idx == 4'd9) ? ACK : BITS;
        end else abort = timeout;
      end
      ACK: begin
        if (fe) begin
          state_n = WAIT_IDLE;
          abort = data_sync[1];
        end else abort = timeout;
      end
      WAIT_IDLE: begin
        if (clk_sync[1] & data_sync[1]) begin
          state_n = IDLE;
          done_n = 1'b1;
          busy_n = 1'b0;
        end else abort = timeout;
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      err_n = 1'b1;
      busy_n = 1'b0;
      clk_drv_n = 1'b0;
      data_drv_n = 1'b0;
    end
    if (state_n != state) cnt_n = '0;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model (20-cycle device clock) driving ps2_host_tx
module tb_ps2_host_tx;
  logic clk = 1'b0, rst = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic dev_clk = 1'b1, dev_low = 1'b0;
  logic ps2_clk_in, ps2_data_in, cdl, ddl, busy, done, err;
  int n_cmp = 0, n_bad = 0, cyc = 0, last_fall = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0;
  logic [1:0] done_busy = '0;
  logic [2:0] drv_after_err = '1;
  logic err_prev = 1'b0, busy_prev = 1'b0;
  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(cdl), .ps2_data_drive_low(ddl),
    .busy(busy), .done(done), .err(err)
  );
  assign ps2_clk_in = dev_clk & ~cdl;
  assign ps2_data_in = ~(ddl | dev_low);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_busy = {busy_prev, busy}; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (done && err) both_cnt++;
    if (err_prev) drv_after_err = {cdl, ddl, busy};
    err_prev = err;
    busy_prev = busy;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask
  // Device side: measure inhibit, then clock out nclk falling edges sampling the data line
  task automatic dev_xfer(input int nclk, input bit ack, output logic [7:0] b, output logic p,
                          output logic s, output int low_cyc, output logic start_ok);
    int w = 0;
    b = '0; p = 1'b0; s = 1'b0; low_cyc = 0;
    while (!cdl && w < 100) begin @(negedge clk); w++; end
    while (cdl && low_cyc < 1000) begin low_cyc++; @(negedge clk); end
    start_ok = ddl;
    repeat (5) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (10) @(negedge clk);
      if (k <= 8) b[k-1] = ps2_data_in;
      else if (k == 9) p = ps2_data_in;
      else if (k == 10) s = ps2_data_in;
      dev_clk = 1'b1;
      if (k == 11) dev_low = 1'b0;
      repeat (5) @(negedge clk);
      if (k == 10 && ack) dev_low = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask
  task automatic full_xfer(input string tag, input logic [7:0] d, input logic par);
    logic [7:0] b;
    logic p, s, so;
    int lc, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send(d);
    dev_xfer(11, 1'b1, b, p, s, lc, so);
    repeat (5) @(negedge clk);
    check({tag, " inhibit"}, lc, 8);
    check({tag, " start"}, so, 1);
    check({tag, " byte"}, b, d);
    check({tag, " parity"}, p, par);
    check({tag, " stop"}, s, 1);
    check({tag, " done"}, done_cnt - d0, 1);
    check({tag, " no err"}, err_cnt - e0, 0);
    check({tag, " busy fall"}, done_busy, 2'b10);
  endtask
  initial begin
    logic [7:0] b;
    logic p, s, so;
    int lc, d0, e0, w;
    repeat (3) @(negedge clk);
    check("reset outs", {cdl, ddl, busy, done, err}, 0);
    tx_start = 1'b1; tx_data = 8'hED;
    @(negedge clk);
    rst = 1'b0; tx_start = 1'b0;
    check("rst over start", {cdl, busy}, 0);
    repeat (3) @(negedge clk);
    check("idle after rst", {cdl, ddl, busy}, 0);
    for (int i = 0; i < 4; i++) begin
      dev_clk = 1'b0; dev_low = i[0];
      repeat (6) @(negedge clk);
      dev_clk = 1'b1;
      repeat (6) @(negedge clk);
      check("idle activity", {cdl, ddl, busy, done, err}, 0);
    end
    dev_low = 1'b0;
    repeat (10) @(negedge clk);
    full_xfer("ED", 8'hED, 1'b1);
    repeat (20) @(negedge clk);
    full_xfer("F4", 8'hF4, 1'b0);
    repeat (20) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5);
    dev_xfer(11, 1'b0, b, p, s, lc, so);
    repeat (5) @(negedge clk);
    check("nack byte", b, 8'hA5);
    check("nack err", err_cnt - e0, 1);
    check("nack no done", done_cnt - d0, 0);
    check("nack release", drv_after_err, 0);
    repeat (20) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C);
    dev_xfer(4, 1'b0, b, p, s, lc, so);
    w = 0;
    while (err_cnt == e0 && w < 400) begin @(negedge clk); w++; end
    check("timeout err", err_cnt - e0, 1);
    check("timeout delay", err_cyc - last_fall, 3 + 200);
    check("timeout release", drv_after_err, 0);
    check("timeout no done", done_cnt - d0, 0);
    repeat (20) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    fork
      dev_xfer(11, 1'b1, b, p, s, lc, so);
      begin
        repeat (60) @(negedge clk);
        tx_data = 8'h00; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    check("busy ignore byte", b, 8'hED);
    check("busy ignore par", p, 1);
    check("busy ignore done", done_cnt - d0, 1);
    repeat (20) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    dev_xfer(4, 1'b0, b, p, s, lc, so);
    check("mid busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid rst release", {cdl, ddl, busy, done, err}, 0);
    repeat (250) @(negedge clk);
    check("mid rst no pulse", {done_cnt - d0, err_cnt - e0}, 0);
    full_xfer("post rst", 8'hED, 1'b1);
    check("done err overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
